// File: rtl/edge_pulse_gen.sv
// Multi-channel edge-to-pulse converter: sync, edge select, fixed-width pulse, sticky miss flag.
// Optional stability filter ahead of edge detection when EDGE_PULSE_DEBOUNCE_EN is defined.

module edge_pulse_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int PULSE_LEN       = 1,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       din_i,
  input  logic [1:0] mode_i,
  input  logic       clear_missed_i,
  output logic       pulse_o,
  output logic       missed_o
);
  localparam int CW = $clog2(PULSE_LEN + 1);
  localparam logic [CW-1:0] LEN = CW'(PULSE_LEN);

  logic          s, lvl, prev_q, edge_det;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, missed_q, missed_d;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = din_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clock_i) begin
        if (reset_i) sync_q <= '0;
        else         sync_q <= (sync_q << 1) | SYNC_STAGES'(din_i);
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

`ifdef EDGE_PULSE_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic          f_q;
  logic [DW-1:0] dcnt_q;
  // f follows s only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      f_q    <= 1'b0;
      dcnt_q <= '0;
    end else if (s == f_q) begin
      dcnt_q <= '0;
    end else if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
      f_q    <= s;
      dcnt_q <= '0;
    end else begin
      dcnt_q <= dcnt_q + DW'(1);
    end
  end
  assign lvl = f_q;
`else
  generate
    if (DEBOUNCE_CYCLES < 0) begin : g_unused_db
    end
  endgenerate
  assign lvl = s;
`endif

  always_comb begin
    case (mode_i)
      2'b00:   edge_det = lvl & ~prev_q;
      2'b01:   edge_det = ~lvl & prev_q;
      2'b10:   edge_det = lvl ^ prev_q;
      default: edge_det = 1'b0;
    endcase
  end

  // pulse_q mirrors (cnt != 0) in the same cycle, so edges on the last pulse cycle are dropped
  always_comb begin
    cnt_d    = cnt_q;
    missed_d = clear_missed_i ? 1'b0 : missed_q;
    if (edge_det && !pulse_q)  cnt_d = LEN;
    else if (cnt_q != '0)      cnt_d = cnt_q - CW'(1);
    if (edge_det && pulse_q)   missed_d = 1'b1;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      prev_q   <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      prev_q   <= lvl;
      cnt_q    <= cnt_d;
      pulse_q  <= (cnt_d != '0);
      missed_q <= missed_d;
    end
  end

  assign pulse_o  = pulse_q;
  assign missed_o = missed_q;
endmodule

module edge_pulse_gen #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int PULSE_LEN       = 1,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic [CHANNELS-1:0] din_i,
  input  logic [1:0]          mode_i,
  input  logic                clear_missed_i,
  output logic [CHANNELS-1:0] pulse_o,
  output logic [CHANNELS-1:0] missed_o
);
  generate
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      edge_pulse_lane #(
        .SYNC_STAGES    (SYNC_STAGES),
        .PULSE_LEN      (PULSE_LEN),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_lane (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .din_i         (din_i[g]),
        .mode_i        (mode_i),
        .clear_missed_i(clear_missed_i),
        .pulse_o       (pulse_o[g]),
        .missed_o      (missed_o[g])
      );
    end
  endgenerate
endmodule
